hazard_ctrl_md: RTL and testbench

Next-generation hazard controller for the 5-stage MIPS pipeline. It combines Tuse/Tnew stall detection and D/E/M forwarding-select generation with an internal busy tracker for a multi-cycle multiply/divide unit. It takes pre-decoded per-stage fields from the stage controllers and drives the F/D stall enables, the E bubble and all forwarding muxes. Register-file width and mult/div latencies are parameters.

---
 rtl/hazard_ctrl_md.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl_md.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_md.sv
// Hazard controller for the 5-stage MIPS pipeline: Tuse/Tnew stall detection,
// D/E/M forwarding selects and a busy tracker for the multi-cycle mult/div unit.
module hazard_ctrl_md #(
    parameter int ADDR_W   = 5,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] D_rs,
    input  logic [ADDR_W-1:0] D_rt,
    input  logic [1:0]        D_tuse_rs,
    input  logic [1:0]        D_tuse_rt,
    input  logic              D_md,
    input  logic [ADDR_W-1:0] E_rs,
    input  logic [ADDR_W-1:0] E_rt,
    input  logic [ADDR_W-1:0] E_wa,
    input  logic              E_we,
    input  logic [1:0]        E_tnew,
    input  logic              E_md_start,
    input  logic              E_md_div,
    input  logic [ADDR_W-1:0] M_rt,
    input  logic [ADDR_W-1:0] M_wa,
    input  logic              M_we,
    input  logic [1:0]        M_tnew,
    input  logic [ADDR_W-1:0] W_wa,
    input  logic              W_we,
    output logic              F_en,
    output logic              D_en,
    output logic              E_clr,
    output logic [1:0]        D_fwd_rs,
    output logic [1:0]        D_fwd_rt,
    output logic [1:0]        E_fwd_rs,
    output logic [1:0]        E_fwd_rt,
    output logic              M_fwd_rt,
    output logic              md_busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);

    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_E  = 2'd1;
    localparam logic [1:0] SEL_M  = 2'd2;
    localparam logic [1:0] SEL_W  = 2'd3;

    // A producer of Tnew 3 never writes in time to matter, so it is not a source.
    function automatic logic src_hit(input logic              we,
                                     input logic [ADDR_W-1:0] wa,
                                     input logic [1:0]        tnew,
                                     input logic [ADDR_W-1:0] src);
        return we && (wa == src) && (src != {ADDR_W{1'b0}}) && (tnew != 2'd3);
    endfunction

    function automatic logic need_stall(input logic       hit,
                                        input logic [1:0] tuse,
                                        input logic [1:0] tnew);
        return hit && (tuse != 2'd3) && (tuse < tnew);
    endfunction

    // The youngest matching producer owns the value; if it is not ready yet, fall back to RF.
    function automatic logic [1:0] d_select(input logic       hit_e,
                                            input logic [1:0] tnew_e,
                                            input logic       hit_m,
                                            input logic [1:0] tnew_m,
                                            input logic       hit_w);
        logic [1:0] sel;
        if (hit_e) begin
            sel = (tnew_e == 2'd0) ? SEL_E : SEL_RF;
        end else if (hit_m) begin
            sel = (tnew_m == 2'd0) ? SEL_M : SEL_RF;
        end else if (hit_w) begin
            sel = SEL_W;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    function automatic logic [1:0] e_select(input logic       hit_m,
                                            input logic [1:0] tnew_m,
                                            input logic       hit_w);
        logic [1:0] sel;
        if (hit_m) begin
            sel = (tnew_m == 2'd0) ? SEL_M : SEL_RF;
        end else if (hit_w) begin
            sel = SEL_W;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    logic             hit_e_drs_s, hit_m_drs_s, hit_w_drs_s;
    logic             hit_e_drt_s, hit_m_drt_s, hit_w_drt_s;
    logic             hit_m_ers_s, hit_w_ers_s;
    logic             hit_m_ert_s, hit_w_ert_s;
    logic             hit_w_mrt_s;
    logic             stall_rs_s, stall_rt_s, stall_md_s, stall_s;
    logic [CNT_W-1:0] md_cnt_nxt_s;
    logic [CNT_W-1:0] md_cnt_r;
    logic             md_busy_r;

    assign hit_e_drs_s = src_hit(E_we, E_wa, E_tnew, D_rs);
    assign hit_m_drs_s = src_hit(M_we, M_wa, M_tnew, D_rs);
    assign hit_w_drs_s = src_hit(W_we, W_wa, 2'd0,   D_rs);
    assign hit_e_drt_s = src_hit(E_we, E_wa, E_tnew, D_rt);
    assign hit_m_drt_s = src_hit(M_we, M_wa, M_tnew, D_rt);
    assign hit_w_drt_s = src_hit(W_we, W_wa, 2'd0,   D_rt);
    assign hit_m_ers_s = src_hit(M_we, M_wa, M_tnew, E_rs);
    assign hit_w_ers_s = src_hit(W_we, W_wa, 2'd0,   E_rs);
    assign hit_m_ert_s = src_hit(M_we, M_wa, M_tnew, E_rt);
    assign hit_w_ert_s = src_hit(W_we, W_wa, 2'd0,   E_rt);
    assign hit_w_mrt_s = src_hit(W_we, W_wa, 2'd0,   M_rt);

    // Stall decision: data not ready for a D source, or MD result still pending.
    always_comb begin
        stall_rs_s = need_stall(hit_e_drs_s, D_tuse_rs, E_tnew)
                   | need_stall(hit_m_drs_s, D_tuse_rs, M_tnew);
        stall_rt_s = need_stall(hit_e_drt_s, D_tuse_rt, E_tnew)
                   | need_stall(hit_m_drt_s, D_tuse_rt, M_tnew);
        stall_md_s = D_md & (E_md_start | md_busy_r);
        stall_s    = stall_rs_s | stall_rt_s | stall_md_s;
    end

    // Forwarding selects and pipeline enables, all zero-latency.
    always_comb begin
        F_en     = ~stall_s;
        D_en     = ~stall_s;
        E_clr    = stall_s;
        D_fwd_rs = d_select(hit_e_drs_s, E_tnew, hit_m_drs_s, M_tnew, hit_w_drs_s);
        D_fwd_rt = d_select(hit_e_drt_s, E_tnew, hit_m_drt_s, M_tnew, hit_w_drt_s);
        E_fwd_rs = e_select(hit_m_ers_s, M_tnew, hit_w_ers_s);
        E_fwd_rt = e_select(hit_m_ert_s, M_tnew, hit_w_ert_s);
        M_fwd_rt = hit_w_mrt_s;
    end

    // Busy counter next state; a start while already busy is ignored.
    always_comb begin
        md_cnt_nxt_s = md_cnt_r;
        if (md_cnt_r != CNT_ZERO) begin
            md_cnt_nxt_s = md_cnt_r - CNT_ONE;
        end else if (E_md_start) begin
            md_cnt_nxt_s = E_md_div ? DIV_LOAD : MULT_LOAD;
        end else begin
            md_cnt_nxt_s = CNT_ZERO;
        end
    end

    // Counter and busy flag registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_r  <= CNT_ZERO;
            md_busy_r <= 1'b0;
        end else begin
            md_cnt_r  <= md_cnt_nxt_s;
            md_busy_r <= (md_cnt_nxt_s != CNT_ZERO);
        end
    end

    assign md_busy = md_busy_r;

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// Directed bench for hazard_ctrl_md: combinational vector table plus
// multi-cycle sequences for the mult/div busy tracker and async reset.
module tb_hazard_ctrl_md;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_rs, E_rt, E_wa, M_rt, M_wa, W_wa;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic       D_md, E_we, E_md_start, E_md_div, M_we, W_we;
    logic       F_en, D_en, E_clr, M_fwd_rt, md_busy;
    logic [1:0] D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;

    hazard_ctrl_md #(.ADDR_W(5), .MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_md(D_md),
        .E_rs(E_rs), .E_rt(E_rt), .E_wa(E_wa), .E_we(E_we), .E_tnew(E_tnew),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .M_rt(M_rt), .M_wa(M_wa), .M_we(M_we), .M_tnew(M_tnew),
        .W_wa(W_wa), .W_we(W_we),
        .F_en(F_en), .D_en(D_en), .E_clr(E_clr),
        .D_fwd_rs(D_fwd_rs), .D_fwd_rt(D_fwd_rt), .E_fwd_rs(E_fwd_rs), .E_fwd_rt(E_fwd_rt),
        .M_fwd_rt(M_fwd_rt), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // exp = {F_en, D_en, E_clr, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, M_fwd_rt}
    typedef struct packed {
        logic [4:0]  d_rs, d_rt;
        logic [1:0]  tu_rs, tu_rt;
        logic        d_md;
        logic [4:0]  e_rs, e_rt, e_wa;
        logic        e_we;
        logic [1:0]  e_tnew;
        logic [4:0]  m_rt, m_wa;
        logic        m_we;
        logic [1:0]  m_tnew;
        logic [4:0]  w_wa;
        logic        w_we;
        logic [11:0] exp;
    } vec_t;

    localparam logic [11:0] GO    = 12'b110_00_00_00_00_0;
    localparam logic [11:0] STALL = 12'b001_00_00_00_00_0;

    vec_t  vq[$];
    string nq[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {F_en, D_en, E_clr, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, M_fwd_rt};
    endfunction

    task automatic add(input string name, input vec_t v);
        vq.push_back(v);
        nq.push_back(name);
    endtask

    task automatic apply(input vec_t v);
        D_rs = v.d_rs; D_rt = v.d_rt; D_tuse_rs = v.tu_rs; D_tuse_rt = v.tu_rt; D_md = v.d_md;
        E_rs = v.e_rs; E_rt = v.e_rt; E_wa = v.e_wa; E_we = v.e_we; E_tnew = v.e_tnew;
        M_rt = v.m_rt; M_wa = v.m_wa; M_we = v.m_we; M_tnew = v.m_tnew;
        W_wa = v.w_wa; W_we = v.w_we;
        E_md_start = 1'b0; E_md_div = 1'b0;
    endtask

    task automatic idle();
        vec_t v;
        v = '0;
        apply(v);
    endtask

    task automatic md_run(input logic div, input int lat, input string nm);
        int st;
        int bz;
        bit done;
        @(negedge clk);
        idle();
        D_md = 1'b1; E_md_start = 1'b1; E_md_div = div;
        #1;
        chk({nm, "_start"}, 16'({F_en, E_clr, md_busy}), 16'(3'b010));
        st = 1; bz = 0; done = 1'b0;
        @(negedge clk);
        E_md_start = 1'b0; E_md_div = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (F_en) begin
                done = 1'b1;
            end else begin
                st++;
                if (md_busy) bz++;
                @(negedge clk);
            end
        end
        chk({nm, "_issued"}, 16'(done), 16'(1'b1));
        chk({nm, "_stall_cycles"}, 16'(st), 16'(lat + 1));
        chk({nm, "_busy_cycles"}, 16'(bz), 16'(lat));
        chk({nm, "_issue_state"}, 16'({md_busy, E_clr, D_en}), 16'(3'b001));
        idle();
    endtask

    initial begin
        vec_t v;
        int   bz;
        bit   done;

        v = '0; v.exp = GO; add("idle", v);
        v = '0; v.e_we = 1; v.e_wa = 8; v.e_tnew = 2; v.d_rs = 8; v.tu_rs = 1; v.exp = STALL; add("loaduse_e", v);
        v = '0; v.m_we = 1; v.m_wa = 8; v.m_tnew = 1; v.d_rs = 8; v.tu_rs = 0; v.exp = STALL; add("loaduse_m_tuse0", v);
        v = '0; v.m_we = 1; v.m_wa = 8; v.m_tnew = 1; v.d_rs = 8; v.tu_rs = 1; v.exp = GO; add("loaduse_m_tuse1", v);
        v = '0; v.w_we = 1; v.w_wa = 8; v.d_rs = 8; v.tu_rs = 1; v.exp = 12'b110_11_00_00_00_0; add("loaduse_w", v);
        v = '0; v.e_we = 1; v.e_wa = 9; v.e_tnew = 1; v.d_rt = 9; v.exp = STALL; add("branch_e", v);
        v = '0; v.m_we = 1; v.m_wa = 9; v.m_tnew = 0; v.d_rt = 9; v.exp = 12'b110_00_10_00_00_0; add("branch_m", v);
        v = '0; v.e_we = 1; v.e_wa = 4; v.m_we = 1; v.m_wa = 4; v.w_we = 1; v.w_wa = 4;
        v.e_rs = 4; v.e_rt = 4; v.d_rs = 4; v.d_rt = 4; v.exp = 12'b110_01_01_10_10_0; add("prio_emw", v);
        v = '0; v.m_we = 1; v.m_wa = 4; v.w_we = 1; v.w_wa = 4;
        v.e_rs = 4; v.d_rs = 4; v.exp = 12'b110_10_00_10_00_0; add("prio_mw", v);
        v = '0; v.w_we = 1; v.w_wa = 4; v.e_rt = 4; v.d_rt = 4; v.m_rt = 4;
        v.exp = 12'b110_00_11_00_11_1; add("prio_w", v);
        v = '0; v.e_we = 1; v.e_tnew = 2; v.m_we = 1; v.m_tnew = 1; v.w_we = 1; v.exp = GO; add("dest_zero", v);
        v = '0; v.m_rt = 5; v.w_we = 1; v.w_wa = 5; v.exp = 12'b110_00_00_00_00_1; add("store_fwd", v);
        v = '0; v.m_rt = 5; v.w_we = 0; v.w_wa = 5; v.exp = GO; add("store_nofwd", v);
        v = '0; v.e_we = 1; v.e_wa = 7; v.e_tnew = 3; v.d_rs = 7; v.exp = GO; add("tnew3", v);
        v = '0; v.e_we = 1; v.e_wa = 7; v.e_tnew = 2; v.d_rs = 7; v.tu_rs = 3; v.exp = GO; add("tuse3", v);
        v = '0; v.e_we = 1; v.e_wa = 4; v.e_tnew = 1; v.m_we = 1; v.m_wa = 4; v.d_rs = 4; v.tu_rs = 2;
        v.e_rs = 4; v.exp = 12'b110_00_00_10_00_0; add("e_shadows_m", v);
        v = '0; v.m_we = 1; v.m_wa = 6; v.m_tnew = 1; v.w_we = 1; v.w_wa = 6; v.e_rs = 6; v.exp = GO; add("m_shadows_w", v);
        v = '0; v.e_we = 1; v.e_wa = 3; v.e_tnew = 2; v.d_rs = 2; v.d_rt = 3; v.tu_rt = 1; v.exp = STALL; add("rt_only_stall", v);
        v = '0; v.d_md = 1; v.exp = GO; add("md_idle", v);

        reset = 1'b0;
        idle();
        #3;
        chk("reset_outs", 16'(outs()), 16'(GO));
        chk("reset_busy", 16'(md_busy), 16'(1'b0));
        @(negedge clk);
        reset = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            apply(vq[i]);
            #1;
            chk(nq[i], 16'(outs()), 16'(vq[i].exp));
        end

        md_run(1'b1, 10, "div");
        md_run(1'b0, 5, "mult");

        // A second start while busy must not reload the counter.
        @(negedge clk);
        idle(); E_md_start = 1'b1;
        @(negedge clk);
        E_md_start = 1'b1; E_md_div = 1'b1;
        @(negedge clk);
        E_md_start = 1'b0; E_md_div = 1'b0;
        bz = 0; done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            #1;
            if (!md_busy) done = 1'b1;
            else begin
                bz++;
                @(negedge clk);
            end
        end
        chk("no_reload_busy_left", 16'(bz), 16'(4));

        // Asynchronous reset while the divider is counting.
        @(negedge clk);
        idle(); E_md_start = 1'b1; E_md_div = 1'b1;
        @(negedge clk);
        E_md_start = 1'b0; E_md_div = 1'b0;
        repeat (4) @(negedge clk);
        D_md = 1'b1;
        #1;
        chk("pre_reset_stall", 16'({md_busy, F_en}), 16'(2'b10));
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_busy", 16'(md_busy), 16'(1'b0));
        chk("async_reset_outs", 16'(outs()), 16'(GO));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_reset_mfhi", 16'({md_busy, F_en, D_en, E_clr}), 16'(4'b0110));
        @(negedge clk);
        #1;
        chk("post_reset_mfhi2", 16'({md_busy, F_en, D_en, E_clr}), 16'(4'b0110));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
